// File: rtl/reduce_gate_pipe_if.sv
// Bus bundle for reduce_gate_pipe: sample inputs, accumulator controls and
// the aligned result outputs. clk/rst stay outside as plain ports.
interface reduce_gate_pipe_if #(
  parameter int N_IN  = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [N_IN-1:0]  din;
  logic [1:0]       mode;
  logic             acc_en;
  logic             acc_clr;
  logic             out_valid;
  logic             dout;
  logic             partial;
  logic             acc_out;
  logic [CNT_W-1:0] res_cnt;

  // Producer of samples / consumer of results
  modport master (
    output in_valid, din, mode, acc_en, acc_clr,
    input  out_valid, dout, partial, acc_out, res_cnt
  );

  // The reduction pipeline itself
  modport slave (
    input  in_valid, din, mode, acc_en, acc_clr,
    output out_valid, dout, partial, acc_out, res_cnt
  );
endinterface

// File: rtl/reduce_gate_pipe.sv
// Pipelined N-input OR/AND/XOR/NOR reduction built as a registered binary
// tree (one tree level per stage), with a delay-matched low-half result,
// a sticky accumulator and a saturating result counter.
module reduce_gate_pipe #(
  parameter int N_IN  = 8,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  reduce_gate_pipe_if.slave bus
);
  localparam int LAT  = $clog2(N_IN);
  localparam int HALF = N_IN / 2;

  localparam logic [1:0] M_OR  = 2'b00;
  localparam logic [1:0] M_AND = 2'b01;
  localparam logic [1:0] M_XOR = 2'b10;
  localparam logic [1:0] M_NOR = 2'b11;

  // Number of tree nodes left after 'level' pairing steps over 'width' leaves.
  function automatic int nodes_at(input int width, input int level);
    return (width + (1 << level) - 1) >> level;
  endfunction

  // Padding value for an unpaired node: neutral element of the operator.
  function automatic logic ident(input logic [1:0] m);
    return (m == M_AND);
  endfunction

  // Two-input tree operator; NOR is carried as OR and inverted at the end.
  function automatic logic op2(input logic [1:0] m, input logic a, input logic b);
    logic r;
    case (m)
      M_AND:   r = a & b;
      M_XOR:   r = a ^ b;
      default: r = a | b;
    endcase
    return r;
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Level 0 is the raw input; levels 1..LAT-1 are registered tree levels.
  // node/part/md/vld are named uniformly across levels so the next level can
  // reach the previous one by index.
  for (genvar l = 0; l < LAT; l++) begin : g_lvl
    localparam int NC = nodes_at(N_IN, l);
    localparam int PC = nodes_at(HALF, l);
    logic [NC-1:0] node;
    logic [PC-1:0] part;
    logic [1:0]    md;
    logic          vld;

    if (l == 0) begin : g_in
      assign node = bus.din;
      assign part = bus.din[PC-1:0];
      assign md   = bus.mode;
      assign vld  = bus.in_valid;
    end else begin : g_reg
      localparam int NP = nodes_at(N_IN, l - 1);
      localparam int PP = nodes_at(HALF, l - 1);
      logic [2*NC-1:0] node_pad;
      logic [2*PC-1:0] part_pad;
      logic [NC-1:0]   node_d;
      logic [PC-1:0]   part_d;

      // Pair up the previous level's nodes, padding the odd one out.
      always_comb begin
        node_d   = '0;
        part_d   = '0;
        node_pad = {(2*NC){ident(g_lvl[l-1].md)}};
        part_pad = {(2*PC){ident(g_lvl[l-1].md)}};
        node_pad[NP-1:0] = g_lvl[l-1].node;
        part_pad[PP-1:0] = g_lvl[l-1].part;
        for (int j = 0; j < NC; j++)
          node_d[j] = op2(g_lvl[l-1].md, node_pad[2*j], node_pad[2*j+1]);
        for (int j = 0; j < PC; j++)
          part_d[j] = op2(g_lvl[l-1].md, part_pad[2*j], part_pad[2*j+1]);
      end

      // Stage l valid bit: the only reset state in the tree.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) vld <= 1'b0;
        else     vld <= g_lvl[l-1].vld;
      end

      // Stage l data and mode; stale contents are harmless while vld is low.
      always_ff @(posedge clk) begin
        node <= node_d;
        part <= part_d;
        md   <= g_lvl[l-1].md;
      end
    end
  end

  // ---- final stage: last pairing, NOR inversion, hold on bubbles ----
  localparam int NF = nodes_at(N_IN, LAT - 1);
  localparam int PF = nodes_at(HALF, LAT - 1);

  logic [1:0] fin_md;
  logic [1:0] fin_node_pad;
  logic [1:0] fin_part_pad;
  logic       fin_or;
  logic       dout_d;
  logic       partial_d;
  logic       out_valid_q;
  logic       dout_q;
  logic       partial_q;
  logic [1:0] out_md_q;

  // Last tree level; only dout sees the NOR inversion, partial never does.
  always_comb begin
    fin_md       = g_lvl[LAT-1].md;
    fin_node_pad = {2{ident(fin_md)}};
    fin_part_pad = {2{ident(fin_md)}};
    fin_node_pad[NF-1:0] = g_lvl[LAT-1].node;
    fin_part_pad[PF-1:0] = g_lvl[LAT-1].part;
    fin_or    = op2(fin_md, fin_node_pad[0], fin_node_pad[1]);
    dout_d    = (fin_md == M_NOR) ? ~fin_or : fin_or;
    partial_d = op2(fin_md, fin_part_pad[0], fin_part_pad[1]);
  end

  // Output register: results only load on valid so they hold across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      dout_q      <= 1'b0;
      partial_q   <= 1'b0;
    end else begin
      out_valid_q <= g_lvl[LAT-1].vld;
      if (g_lvl[LAT-1].vld) begin
        dout_q    <= dout_d;
        partial_q <= partial_d;
      end
    end
  end

  // Mode of the result currently on the outputs, needed by the accumulator.
  always_ff @(posedge clk) begin
    out_md_q <= fin_md;
  end

  // ---- accumulator and result counter ----
  logic             acc_q,   acc_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Clear first, then fold in a result present in the same cycle.
  always_comb begin
    acc_d   = acc_q;
    first_d = first_q;
    cnt_d   = cnt_q;
    if (bus.acc_clr) begin
      acc_d   = 1'b0;
      first_d = 1'b1;
      cnt_d   = '0;
    end
    if (out_valid_q) begin
      cnt_d = sat_inc(cnt_d);
      if (bus.acc_en) begin
        if (first_d) acc_d = dout_q;
        else         acc_d = op2(out_md_q, acc_d, dout_q);
        first_d = 1'b0;
      end
    end
  end

  // Accumulator state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= 1'b0;
      first_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.partial   = partial_q;
  assign bus.acc_out   = acc_q;
  assign bus.res_cnt   = cnt_q;
endmodule
